// File: rtl/cache_mem_arbiter.sv
// Shares one burst-mode memory port between the I-cache and D-cache controllers.
// It moves one full line at a time and turns each line into a sequence of memory beats.
module cache_mem_arbiter #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BURST_W-1:0] mem_wdata,
    input  logic [BURST_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam int unsigned BEATS = LINE_W / BURST_W;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(32'h1F);
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        DONE
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [LINE_W-1:0]  line_buf, buf_next;
    logic [ADDR_W-1:0]  addr_q, addr_next;
    logic               last_grant, grant_next;
    logic               d_req;

    assign d_req = d_read | d_write;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            line_buf   <= '0;
            addr_q     <= '0;
            last_grant <= GRANT_I;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            line_buf   <= buf_next;
            addr_q     <= addr_next;
            last_grant <= grant_next;
        end
    end

    // Next-state, grant and beat bookkeeping
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        buf_next   = line_buf;
        addr_next  = addr_q;
        grant_next = last_grant;
        case (state)
            IDLE: begin
                // On a conflict, the cache that lost the previous grant wins.
                if (i_read && (!d_req || last_grant == GRANT_D)) begin
                    state_next = I_RD;
                    addr_next  = i_addr;
                    grant_next = GRANT_I;
                    cnt_next   = '0;
                end else if (d_req) begin
                    state_next = d_write ? D_WR : D_RD;
                    addr_next  = d_addr;
                    grant_next = GRANT_D;
                    cnt_next   = '0;
                    if (d_write) begin
                        buf_next = d_wdata;
                    end
                end
            end
            I_RD, D_RD: begin
                if (mem_resp) begin
                    buf_next[cnt*BURST_W +: BURST_W] = mem_rdata;
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt == LAST_BEAT) begin
                        state_next = DONE;
                    end
                end
            end
            D_WR: begin
                if (mem_resp) begin
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt == LAST_BEAT) begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory-side outputs depend only on registered state, so they have no path from the request inputs.
    assign mem_read  = (state == I_RD) || (state == D_RD);
    assign mem_write = (state == D_WR);
    assign mem_addr  = addr_q & LINE_MASK;
    assign mem_wdata = (state == D_WR) ? line_buf[cnt*BURST_W +: BURST_W] : '0;

    assign i_resp  = (state == DONE) && (last_grant == GRANT_I);
    assign d_resp  = (state == DONE) && (last_grant == GRANT_D);
    assign i_rdata = line_buf;
    assign d_rdata = line_buf;

endmodule
